// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit and the branch-condition decoder.
// Holds the branch-type encoding, flag bit positions, 2-bit counter states,
// the resolve FSM state type and the saturating counter update helper.
package branch_predict_unit_pkg;

    // Branch type encoding carried on ex_btype.
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_JZ   = 3'd1;
    localparam logic [2:0] BR_JN   = 3'd2;
    localparam logic [2:0] BR_JC   = 3'd3;
    localparam logic [2:0] BR_JV   = 3'd4;
    localparam logic [2:0] BR_LOOP = 3'd5;
    localparam logic [2:0] BR_JMP  = 3'd6;
    localparam logic [2:0] BR_RET  = 3'd7;

    // Bit positions inside ex_flags.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Resolve FSM: IDLE resolves and trains, FLUSH ignores wrong-path ex_* inputs.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } bpu_state_t;

    // Move a counter one step toward the observed outcome, saturating at SNT/ST.
    function automatic logic [1:0] ctr_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_table.sv
// bpu_table: direct-mapped predictor storage, 2**IDX_W entries of
// {2-bit counter, PC_W target}. Asynchronous reads, one synchronous write
// port, asynchronous reset to counter=WNT, target=0.
// Ports:
//   clk, rst        clock, async active-high reset
//   rd_idx_i        fetch-side lookup index -> rd_cnt_o, rd_tgt_o
//   wr_idx_i        training index; wr_cnt_o returns the entry's current counter
//   wr_en_i         write the counter at wr_idx_i with wr_cnt_i
//   wr_tgt_en_i     additionally write the target with wr_tgt_i (needs wr_en_i)
module bpu_table
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    output logic [PC_W-1:0]  rd_tgt_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    output logic [1:0]       wr_cnt_o,
    input  logic             wr_en_i,
    input  logic             wr_tgt_en_i,
    input  logic [1:0]       wr_cnt_i,
    input  logic [PC_W-1:0]  wr_tgt_i
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]      cnt_q [DEPTH];
    logic [PC_W-1:0] tgt_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= WNT;
                tgt_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= wr_cnt_i;
            if (wr_tgt_en_i) tgt_q[wr_idx_i] <= wr_tgt_i;
        end
    end

    // No bypass: a lookup in the write cycle sees the old entry.
    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign rd_tgt_o = tgt_q[rd_idx_i];
    assign wr_cnt_o = cnt_q[wr_idx_i];

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch-stage branch prediction plus execute-stage
// resolve, training and mispredict redirect/flush sequencing.
// Lookup side:  fetch_pc -> pred_taken, pred_target (combinational).
// Resolve side: ex_* inputs -> b_take (combinational); on mispredict a
//   registered one-cycle redirect_valid pulse, held redirect_pc, and flush
//   high for FLUSH_CYCLES cycles.
// Optional feature macro BPU_STATS_EN adds stat_branches / stat_mispredicts.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [2:0]      ex_btype,
    input  logic [3:0]      ex_flags,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] ex_next_pc,
    output logic            b_take,
`ifdef BPU_STATS_EN
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts,
`endif
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    bpu_state_t      state_q, state_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;

    logic [1:0]      rd_cnt;
    logic [1:0]      cur_cnt;
    logic            resolve_active;
    logic            cond_true;
    logic            mispredict;
    logic            wr_en;
    logic            wr_tgt_en;
    logic [1:0]      wr_cnt;

    // Index bits only: the table has no tag, upper PC bits are unused.
    logic unused_pc_hi;
    assign unused_pc_hi = ^{fetch_pc[PC_W-1:IDX_W], ex_pc[PC_W-1:IDX_W]};

    bpu_table #(
        .PC_W (PC_W),
        .IDX_W(IDX_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (fetch_pc[IDX_W-1:0]),
        .rd_cnt_o   (rd_cnt),
        .rd_tgt_o   (pred_target),
        .wr_idx_i   (ex_pc[IDX_W-1:0]),
        .wr_cnt_o   (cur_cnt),
        .wr_en_i    (wr_en),
        .wr_tgt_en_i(wr_tgt_en),
        .wr_cnt_i   (wr_cnt),
        .wr_tgt_i   (ex_target)
    );

    assign pred_taken = rd_cnt[1];

    // Branch-condition decode, same encoding as the original decoder.
    always_comb begin
        cond_true = 1'b0;
        case (ex_btype)
            BR_JZ, BR_LOOP: cond_true = ex_flags[FLAG_Z];
            BR_JN:          cond_true = ex_flags[FLAG_N];
            BR_JC:          cond_true = ex_flags[FLAG_C];
            BR_JV:          cond_true = ex_flags[FLAG_V];
            BR_JMP, BR_RET: cond_true = 1'b1;
            default:        cond_true = 1'b0;
        endcase
    end

    // In FLUSH the execute instruction is wrong-path and must not resolve.
    assign resolve_active = ex_valid && (state_q == S_IDLE);
    assign b_take         = resolve_active && cond_true;
    assign mispredict     = resolve_active &&
                            ((b_take != ex_pred_taken) ||
                             (b_take && (ex_pred_target != ex_target)));

    // Training: conditional types step the counter; JMP forces strongly taken.
    // RET is never trained because its target depends on the return stack.
    always_comb begin
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        wr_cnt    = cur_cnt;
        if (resolve_active) begin
            case (ex_btype)
                BR_JZ, BR_JN, BR_JC, BR_JV, BR_LOOP: begin
                    wr_en     = 1'b1;
                    wr_tgt_en = b_take;
                    wr_cnt    = ctr_update(cur_cnt, b_take);
                end
                BR_JMP: begin
                    wr_en     = 1'b1;
                    wr_tgt_en = 1'b1;
                    wr_cnt    = ST;
                end
                default: ;
            endcase
        end
    end

    // FSM next state: fcnt counts the remaining FLUSH cycles down to 0.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d = S_FLUSH;
                    fcnt_d  = CW'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) state_d = S_IDLE;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_valid_q <= mispredict;
            if (mispredict) redirect_pc_q <= b_take ? ex_target : ex_next_pc;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == S_FLUSH);

`ifdef BPU_STATS_EN
    logic [15:0] stat_branches_q;
    logic [15:0] stat_mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (resolve_active && (ex_btype != BR_NONE)) stat_branches_q <= stat_branches_q + 16'd1;
            if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with default parameters
// (PC_W=8, IDX_W=4, FLUSH_CYCLES=2). Inputs change on the falling edge,
// outputs are checked mid-cycle, away from the rising edge.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] fetch_pc;
  logic       pred_taken;
  logic [7:0] pred_target;
  logic       ex_valid;
  logic [7:0] ex_pc;
  logic [2:0] ex_btype;
  logic [3:0] ex_flags;
  logic       ex_pred_taken;
  logic [7:0] ex_pred_target;
  logic [7:0] ex_target;
  logic [7:0] ex_next_pc;
  logic       b_take;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       flush;
`ifdef BPU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int n_cmp;
  int n_err;

  branch_predict_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_btype      (ex_btype),
    .ex_flags      (ex_flags),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_target     (ex_target),
    .ex_next_pc    (ex_next_pc),
    .b_take        (b_take),
`ifdef BPU_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_ex(input logic [2:0] bt, input logic [7:0] pc, input logic [3:0] fl,
                          input logic pt, input logic [7:0] ptgt, input logic [7:0] tgt,
                          input logic [7:0] npc);
    ex_valid = 1'b1; ex_btype = bt; ex_pc = pc; ex_flags = fl;
    ex_pred_taken = pt; ex_pred_target = ptgt; ex_target = tgt; ex_next_pc = npc;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_btype = BR_NONE; ex_pc = 8'h00; ex_flags = 4'h0;
    ex_pred_taken = 1'b0; ex_pred_target = 8'h00; ex_target = 8'h00; ex_next_pc = 8'h00;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_pc = 8'h05; idle_ex();
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 8'h00) begin n_err++; $display("FAIL reset_pred_target got %h exp 00", pred_target); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b exp 0", flush); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid got %b exp 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h00) begin n_err++; $display("FAIL reset_redirect_pc got %h exp 00", redirect_pc); end
    next_cycle(); next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  // JZ taken, predicted not-taken: redirect to target, entry 5 counter 1 -> 2.
  task automatic test_mispredict_taken();
    drive_ex(BR_JZ, 8'h05, 4'b0001, 1'b0, 8'h00, 8'h20, 8'h06);
    #1;
    n_cmp++; if (b_take !== 1'b1) begin n_err++; $display("FAIL jz_b_take got %b exp 1", b_take); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL jz_rv_same_cycle got %b exp 0", redirect_valid); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL jz_no_bypass got %b exp 0", pred_taken); end
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jz_rv_n1 got %b exp 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h20) begin n_err++; $display("FAIL jz_rpc got %h exp 20", redirect_pc); end
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jz_flush_n1 got %b exp 1", flush); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jz_pred_taken got %b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 8'h20) begin n_err++; $display("FAIL jz_pred_target got %h exp 20", pred_target); end
    next_cycle(); #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL jz_rv_n2 got %b exp 0", redirect_valid); end
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jz_flush_n2 got %b exp 1", flush); end
    next_cycle(); #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL jz_flush_n3 got %b exp 0", flush); end
    n_cmp++; if (redirect_pc !== 8'h20) begin n_err++; $display("FAIL jz_rpc_held got %h exp 20", redirect_pc); end
  endtask

  // Entry 5 starts at counter 2: two correct taken (2->3, 3 stays 3), then
  // two not-taken mispredicts (3->2 still taken, 2->1 not taken).
  task automatic test_saturation();
    fetch_pc = 8'h05;
    for (int i = 0; i < 2; i++) begin
      drive_ex(BR_JZ, 8'h05, 4'b0001, 1'b1, 8'h20, 8'h20, 8'h06);
      next_cycle(); idle_ex(); #1;
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL sat_correct_rv[%0d] got %b exp 0", i, redirect_valid); end
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL sat_correct_flush[%0d] got %b exp 0", i, flush); end
    end
    drive_ex(BR_JZ, 8'h05, 4'b0000, 1'b1, 8'h20, 8'h20, 8'h06);
    #1;
    n_cmp++; if (b_take !== 1'b0) begin n_err++; $display("FAIL nt1_b_take got %b exp 0", b_take); end
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL nt1_rv got %b exp 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h06) begin n_err++; $display("FAIL nt1_rpc got %h exp 06", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL nt1_pred (ctr 2) got %b exp 1", pred_taken); end
    next_cycle(); next_cycle();
    drive_ex(BR_JZ, 8'h05, 4'b0000, 1'b1, 8'h20, 8'h20, 8'h16);
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL nt2_rv got %b exp 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h16) begin n_err++; $display("FAIL nt2_rpc got %h exp 16", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL nt2_pred (ctr 1) got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 8'h20) begin n_err++; $display("FAIL nt2_target_kept got %h exp 20", pred_target); end
    next_cycle(); next_cycle();
  endtask

  // Mispredict in N, JMP mispredict in N+1 during FLUSH must be ignored.
  task automatic test_back_to_back();
    drive_ex(BR_JZ, 8'h07, 4'b0001, 1'b0, 8'h00, 8'h30, 8'h08);
    next_cycle();
    drive_ex(BR_JMP, 8'h0A, 4'b0000, 1'b0, 8'h00, 8'h44, 8'h0B);
    #1;
    n_cmp++; if (b_take !== 1'b0) begin n_err++; $display("FAIL b2b_b_take_in_flush got %b exp 0", b_take); end
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rv_first got %b exp 1", redirect_valid); end
    next_cycle(); idle_ex(); fetch_pc = 8'h0A; #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_second_rv got %b exp 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h30) begin n_err++; $display("FAIL b2b_rpc got %h exp 30", redirect_pc); end
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL b2b_flush_n2 got %b exp 1", flush); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL b2b_no_write_pred got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 8'h00) begin n_err++; $display("FAIL b2b_no_write_tgt got %h exp 00", pred_target); end
    next_cycle(); fetch_pc = 8'h07; #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL b2b_flush_end got %b exp 0", flush); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL b2b_e7_pred got %b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 8'h30) begin n_err++; $display("FAIL b2b_e7_tgt got %h exp 30", pred_target); end
  endtask

  // RET redirects but never trains; JMP at 0x19 aliases entry 9.
  task automatic test_ret_alias();
    fetch_pc = 8'h09;
    drive_ex(BR_RET, 8'h09, 4'b0000, 1'b0, 8'h00, 8'h55, 8'h0A);
    #1;
    n_cmp++; if (b_take !== 1'b1) begin n_err++; $display("FAIL ret_b_take got %b exp 1", b_take); end
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL ret_rv got %b exp 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h55) begin n_err++; $display("FAIL ret_rpc got %h exp 55", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ret_e9_pred got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 8'h00) begin n_err++; $display("FAIL ret_e9_tgt got %h exp 00", pred_target); end
    next_cycle(); next_cycle();
    drive_ex(BR_JMP, 8'h19, 4'b0000, 1'b0, 8'h00, 8'h66, 8'h1A);
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_pc !== 8'h66) begin n_err++; $display("FAIL jmp_rpc got %h exp 66", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_e9_pred got %b exp 1", pred_taken); end
    n_cmp++; if (pred_target !== 8'h66) begin n_err++; $display("FAIL alias_e9_tgt got %h exp 66", pred_target); end
    next_cycle(); next_cycle();
  endtask

  // Condition decode sweep; predictions match, so no redirect may appear.
  task automatic test_decode();
    logic [2:0] bt_v [13];
    logic [3:0] fl_v [13];
    logic       ex_v [13];
    bt_v = '{BR_NONE, BR_JZ, BR_JZ, BR_JN, BR_JN, BR_JC, BR_JC, BR_JV, BR_JV, BR_LOOP, BR_LOOP, BR_JMP, BR_RET};
    fl_v = '{4'hF, 4'h1, 4'hE, 4'h2, 4'hD, 4'h4, 4'hB, 4'h8, 4'h7, 4'h1, 4'h0, 4'h0, 4'h0};
    ex_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      drive_ex(bt_v[i], 8'h0F, fl_v[i], ex_v[i], 8'h70, 8'h70, 8'h10);
      #1;
      n_cmp++; if (b_take !== ex_v[i]) begin n_err++; $display("FAIL decode_b_take[%0d] bt=%0d fl=%h got %b exp %b", i, bt_v[i], fl_v[i], b_take, ex_v[i]); end
      next_cycle(); #1;
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL decode_rv[%0d] got %b exp 0", i, redirect_valid); end
    end
    drive_ex(BR_JMP, 8'h0F, 4'h0, 1'b0, 8'h00, 8'h70, 8'h10);
    ex_valid = 1'b0;
    #1;
    n_cmp++; if (b_take !== 1'b0) begin n_err++; $display("FAIL decode_invalid_b_take got %b exp 0", b_take); end
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL decode_invalid_rv got %b exp 0", redirect_valid); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL decode_flush got %b exp 0", flush); end
  endtask

  // Reset during flush clears outputs and table asynchronously.
  task automatic test_reset_mid_flush();
    fetch_pc = 8'h07;
    drive_ex(BR_JN, 8'h03, 4'b0010, 1'b0, 8'h00, 8'h3C, 8'h04);
    next_cycle(); idle_ex(); #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL rmf_flush_before got %b exp 1", flush); end
    rst = 1'b1;
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rmf_flush got %b exp 0", flush); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rmf_rv got %b exp 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 8'h00) begin n_err++; $display("FAIL rmf_rpc got %h exp 00", redirect_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rmf_e7_pred got %b exp 0", pred_taken); end
    n_cmp++; if (pred_target !== 8'h00) begin n_err++; $display("FAIL rmf_e7_tgt got %h exp 00", pred_target); end
`ifdef BPU_STATS_EN
    n_cmp++; if (stat_branches !== 16'd0) begin n_err++; $display("FAIL rmf_stat_branches got %0d exp 0", stat_branches); end
    n_cmp++; if (stat_mispredicts !== 16'd0) begin n_err++; $display("FAIL rmf_stat_mispredicts got %0d exp 0", stat_mispredicts); end
`endif
    next_cycle();
    rst = 1'b0;
    next_cycle(); #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rmf_after_release got %b exp 0", flush); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mispredict_taken();
    test_saturation();
    test_back_to_back();
    test_ret_alias();
    test_decode();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
